// File: rtl/alu.sv
// 8-bit registered ALU for the execute stage.
// Result, zero and parity are all registered together with one-cycle latency.

package definitions;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      SUB = 3'd1,
      AND = 3'd2,
      OR  = 3'd3,
      XOR = 3'd4,
      NOT = 3'd5,
      SLL = 3'd6,
      SRL = 3'd7
   } op_code;

endpackage

module alu
   import definitions::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rs_i,
   input  logic [7:0] rt_i,
   input  op_code     op_i,
   output logic [7:0] result_o,
   output logic       zero,
   output logic       parity
);

   logic [7:0] res_d;
   logic [7:0] res_q;
   logic       zero_q;
   logic       par_q;
   logic [2:0] shamt;

   assign shamt = rt_i[2:0];

   // Unknown opcodes fall to the default and yield zero.
   always_comb begin
      res_d = 8'h00;
      case (op_i)
         ADD:     res_d = rs_i + rt_i;
         SUB:     res_d = rs_i - rt_i;
         AND:     res_d = rs_i & rt_i;
         OR:      res_d = rs_i | rt_i;
         XOR:     res_d = rs_i ^ rt_i;
         NOT:     res_d = ~rs_i;
         SLL:     res_d = rs_i << shamt;
         SRL:     res_d = rs_i >> shamt;
         default: res_d = 8'h00;
      endcase
   end

   // Flags are derived from the new result so they never lag result_o.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_q  <= 8'h00;
         zero_q <= 1'b1;
         par_q  <= 1'b0;
      end else begin
         res_q  <= res_d;
         zero_q <= ~|res_d;
         par_q  <= ^res_d;
      end
   end

   assign result_o = res_q;
   assign zero     = zero_q;
   assign parity   = par_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu.
// Hand-computed vectors cover every opcode, wrap cases, latency and async reset.

module tb_alu;
   import definitions::*;

   logic       clk;
   logic       reset;
   logic [7:0] rs_i;
   logic [7:0] rt_i;
   op_code     op_i;
   logic [7:0] result_o;
   logic       zero;
   logic       parity;

   int checks;
   int failures;

   alu dut (
      .clk      (clk),
      .reset    (reset),
      .rs_i     (rs_i),
      .rt_i     (rt_i),
      .op_i     (op_i),
      .result_o (result_o),
      .zero     (zero),
      .parity   (parity)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] r,
                      input logic z, input logic p);
      checks++;
      assert ({result_o, zero, parity} === {r, z, p})
      else begin
         failures++;
         $error("FAIL %s: got result=%02h zero=%0b parity=%0b, want result=%02h zero=%0b parity=%0b",
                tag, result_o, zero, parity, r, z, p);
      end
   endtask

   task automatic step(input op_code op, input logic [7:0] a,
                       input logic [7:0] b);
      @(negedge clk);
      op_i = op;
      rs_i = a;
      rt_i = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      rs_i     = 8'd16;
      rt_i     = 8'd24;
      op_i     = XOR;

      #1;
      chk("reset_t0", 8'h00, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_held", 8'h00, 1'b1, 1'b0);

      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_reset_xor", 8'h08, 1'b0, 1'b1);

      step(AND, 8'b00110011, 8'b11001010);
      chk("and_odd", 8'b00000010, 1'b0, 1'b1);
      step(AND, 8'b10010100, 8'b10011000);
      chk("and_even", 8'b10010000, 1'b0, 1'b0);

      step(ADD, 8'd4, 8'd8);
      chk("add_4_8", 8'd12, 1'b0, 1'b0);
      step(ADD, 8'd20, 8'd24);
      chk("add_20_24", 8'd44, 1'b0, 1'b1);
      step(ADD, 8'hFF, 8'h01);
      chk("add_wrap", 8'h00, 1'b1, 1'b0);

      step(SUB, 8'd4, 8'd8);
      chk("sub_wrap", 8'hFC, 1'b0, 1'b0);
      step(SUB, 8'd28, 8'd28);
      chk("sub_zero", 8'h00, 1'b1, 1'b0);

      step(OR, 8'hA0, 8'h05);
      chk("or", 8'hA5, 1'b0, 1'b0);
      step(XOR, 8'hFF, 8'h0F);
      chk("xor", 8'hF0, 1'b0, 1'b0);
      step(NOT, 8'h01, 8'h5A);
      chk("not", 8'hFE, 1'b0, 1'b1);

      step(SLL, 8'h81, 8'hFB);
      chk("sll_3", 8'h08, 1'b0, 1'b1);
      step(SLL, 8'h81, 8'h08);
      chk("sll_0", 8'h81, 1'b0, 1'b0);
      step(SRL, 8'h81, 8'h01);
      chk("srl_1", 8'h40, 1'b0, 1'b1);
      step(SRL, 8'h80, 8'h0F);
      chk("srl_7", 8'h01, 1'b0, 1'b1);
      step(SRL, 8'h3C, 8'h00);
      chk("srl_0", 8'h3C, 1'b0, 1'b0);

      // Inputs changed between edges must not show until the next edge.
      step(ADD, 8'd1, 8'd2);
      chk("lat_before", 8'd3, 1'b0, 1'b0);
      #2;
      op_i = SUB;
      rs_i = 8'd10;
      rt_i = 8'd3;
      #1;
      chk("lat_hold", 8'd3, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("lat_update", 8'd7, 1'b0, 1'b1);

      // Reset asserted between edges clears outputs at once.
      #1;
      reset = 1'b1;
      #1;
      chk("async_reset", 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      op_i  = OR;
      rs_i  = 8'h70;
      rt_i  = 8'h01;
      @(posedge clk);
      #1;
      chk("after_async", 8'h71, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
